// File: rtl/gpr_wb.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_wb
//  Description : GPR writeback stage. Registers a two-slot result bundle onto
//                the register-file write ports and merges a debug write into
//                a free port with a bounded wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb #(
    parameter int WAIT_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_a_en,
    input  logic [4:0]  in_a_reg,
    input  logic [31:0] in_a_val,
    input  logic        in_b_en,
    input  logic [4:0]  in_b_reg,
    input  logic [31:0] in_b_val,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_reg,
    input  logic [31:0] dbg_val,
    output logic        dbg_ack,
    output logic        write_a_en,
    output logic [4:0]  write_a_select,
    output logic [31:0] write_a_val,
    output logic        write_b_en,
    output logic [4:0]  write_b_select,
    output logic [31:0] write_b_val,
    output logic        coll_err
);

    localparam logic [3:0] c_wait_max = 4'(WAIT_MAX);

    logic [3:0] r_wait_cnt;

    logic w_acc;
    logic w_a_used;
    logic w_b_used;
    logic w_coll;
    logic w_dbg_elig;
    logic w_dbg_clash;
    logic w_place_a;
    logic w_place_b;

    assign in_ready = !reset && (r_wait_cnt < c_wait_max);
    assign w_acc    = in_valid && in_ready;

    // Slot A wins a same-register pair; slot B is dropped and flagged.
    assign w_coll   = w_acc && in_a_en && in_b_en && (in_a_reg == in_b_reg);
    assign w_a_used = w_acc && in_a_en;
    assign w_b_used = w_acc && in_b_en && !w_coll;

    // A debug write to a register the bundle also writes would race it, so
    // it waits instead of sharing the cycle.
    assign w_dbg_elig  = dbg_req && !dbg_ack && !reset;
    assign w_dbg_clash = (w_a_used && (dbg_reg == in_a_reg)) ||
                         (w_b_used && (dbg_reg == in_b_reg));
    assign w_place_b   = w_dbg_elig && !w_dbg_clash && !w_b_used;
    assign w_place_a   = w_dbg_elig && !w_dbg_clash && w_b_used && !w_a_used;

    always_ff @(posedge clk) begin
        if (reset) begin
            write_a_en     <= 1'b0;
            write_a_select <= 5'd0;
            write_a_val    <= 32'd0;
            write_b_en     <= 1'b0;
            write_b_select <= 5'd0;
            write_b_val    <= 32'd0;
            dbg_ack        <= 1'b0;
            coll_err       <= 1'b0;
            r_wait_cnt     <= 4'd0;
        end else begin
            write_a_en     <= w_a_used || w_place_a;
            write_a_select <= w_a_used ? in_a_reg : (w_place_a ? dbg_reg : 5'd0);
            write_a_val    <= w_a_used ? in_a_val : (w_place_a ? dbg_val : 32'd0);
            write_b_en     <= w_b_used || w_place_b;
            write_b_select <= w_b_used ? in_b_reg : (w_place_b ? dbg_reg : 5'd0);
            write_b_val    <= w_b_used ? in_b_val : (w_place_b ? dbg_val : 32'd0);
            dbg_ack        <= w_place_a || w_place_b;
            coll_err       <= w_coll;

            if (!dbg_req || w_place_a || w_place_b) begin
                r_wait_cnt <= 4'd0;
            end else if (w_dbg_elig && (r_wait_cnt != 4'hF)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    a_no_same_reg_dual_write: assert property (@(posedge clk)
        !(write_a_en && write_b_en && (write_a_select == write_b_select)));

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_wb
//  Description : Self-checking bench for gpr_wb: directed scenarios followed
//                by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb;

    localparam int WM = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_a_en;
    logic [4:0]  in_a_reg;
    logic [31:0] in_a_val;
    logic        in_b_en;
    logic [4:0]  in_b_reg;
    logic [31:0] in_b_val;
    logic        dbg_req;
    logic [4:0]  dbg_reg;
    logic [31:0] dbg_val;
    logic        dbg_ack;
    logic        write_a_en;
    logic [4:0]  write_a_select;
    logic [31:0] write_a_val;
    logic        write_b_en;
    logic [4:0]  write_b_select;
    logic [31:0] write_b_val;
    logic        coll_err;

    int n_tests = 0;
    int n_fail  = 0;

    gpr_wb #(.WAIT_MAX(WM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_en(in_a_en), .in_a_reg(in_a_reg), .in_a_val(in_a_val),
        .in_b_en(in_b_en), .in_b_reg(in_b_reg), .in_b_val(in_b_val),
        .dbg_req(dbg_req), .dbg_reg(dbg_reg), .dbg_val(dbg_val), .dbg_ack(dbg_ack),
        .write_a_en(write_a_en), .write_a_select(write_a_select), .write_a_val(write_a_val),
        .write_b_en(write_b_en), .write_b_select(write_b_select), .write_b_val(write_b_val),
        .coll_err(coll_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_a_en = 0; in_a_reg = 0; in_a_val = 0;
        in_b_en = 0; in_b_reg = 0; in_b_val = 0;
    endtask

    task automatic bundle(input logic a_en, input logic [4:0] a_reg, input logic [31:0] a_val,
                          input logic b_en, input logic [4:0] b_reg, input logic [31:0] b_val);
        in_valid = 1; in_a_en = a_en; in_a_reg = a_reg; in_a_val = a_val;
        in_b_en = b_en; in_b_reg = b_reg; in_b_val = b_val;
    endtask

    task automatic test_reset();
        reset = 1; idle(); dbg_req = 0; dbg_reg = 0; dbg_val = 0;
        tick(); tick();
        n_tests++;
        if ({write_a_en, write_a_select, write_a_val, write_b_en, write_b_select, write_b_val,
             dbg_ack, coll_err, in_ready} !== 79'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%b/%0d/%h b=%b/%0d/%h ack=%b coll=%b rdy=%b, want all 0",
                     write_a_en, write_a_select, write_a_val, write_b_en, write_b_select,
                     write_b_val, dbg_ack, coll_err, in_ready);
        end
        reset = 0; #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        bundle(1, 5'd5, 32'h12345678, 0, 5'd0, 32'd0);
        tick(); idle();
        n_tests++;
        if ({write_a_en, write_a_select, write_a_val, write_b_en} !== {1'b1, 5'd5, 32'h12345678, 1'b0}) begin
            n_fail++;
            $display("FAIL single: a=%b/%0d/%h b_en=%b want 1/5/12345678 b_en=0",
                     write_a_en, write_a_select, write_a_val, write_b_en);
        end
        tick();
        n_tests++;
        if ({write_a_en, write_b_en} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: en=%b%b want 00", write_a_en, write_b_en);
        end
    endtask

    task automatic test_dual();
        bundle(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        tick(); idle();
        n_tests++;
        if ({write_a_en, write_a_select, write_a_val, write_b_en, write_b_select, write_b_val, coll_err}
            !== {1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0}) begin
            n_fail++;
            $display("FAIL dual: a=%b/%0d/%h b=%b/%0d/%h coll=%b want 1/3/1 1/4/2 coll=0",
                     write_a_en, write_a_select, write_a_val, write_b_en, write_b_select,
                     write_b_val, coll_err);
        end
        tick();
    endtask

    task automatic test_collision();
        bundle(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
        tick(); idle();
        n_tests++;
        if ({write_a_en, write_a_select, write_a_val, write_b_en, coll_err}
            !== {1'b1, 5'd7, 32'hAAAA, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL collision: a=%b/%0d/%h b_en=%b coll=%b want 1/7/aaaa b_en=0 coll=1",
                     write_a_en, write_a_select, write_a_val, write_b_en, coll_err);
        end
        tick();
        n_tests++;
        if (coll_err !== 1'b0) begin n_fail++; $display("FAIL collision_pulse: coll=%b want 0", coll_err); end
    endtask

    task automatic test_debug_free();
        bundle(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
        dbg_req = 1; dbg_reg = 5'd9; dbg_val = 32'hDEAD;
        tick(); idle();
        n_tests++;
        if ({write_a_en, write_a_select, write_a_val, write_b_en, write_b_select, write_b_val, dbg_ack}
            !== {1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'hDEAD, 1'b1}) begin
            n_fail++;
            $display("FAIL debug_free: a=%b/%0d/%h b=%b/%0d/%h ack=%b want 1/1/11 1/9/dead ack=1",
                     write_a_en, write_a_select, write_a_val, write_b_en, write_b_select,
                     write_b_val, dbg_ack);
        end
        tick();  // request still high during the ack cycle: must be ignored
        dbg_req = 0;
        n_tests++;
        if ({dbg_ack, write_a_en, write_b_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL debug_no_repeat: ack=%b en=%b%b want 0 00", dbg_ack, write_a_en, write_b_en);
        end
        tick();
    endtask

    task automatic test_starvation();
        bit placed = 0;
        int edges  = 0;
        bundle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
        dbg_req = 1; dbg_reg = 5'd2; dbg_val = 32'hC0DE;
        for (int e = 1; e <= WM + 1 && !placed; e++) begin
            tick();
            edges = e;
            if (dbg_ack) begin
                placed = 1;
            end else begin
                n_tests++;
                if ({in_ready, write_a_select, write_b_select} !== {(e < WM), 5'd10, 5'd11}) begin
                    n_fail++;
                    $display("FAIL starve_edge%0d: rdy=%b sel=%0d/%0d want rdy=%b sel=10/11",
                             e, in_ready, write_a_select, write_b_select, (e < WM));
                end
            end
        end
        n_tests++;
        if (!placed || edges != WM + 1) begin
            n_fail++; $display("FAIL starve_bound: placed=%b at edge %0d want edge %0d", placed, edges, WM + 1);
        end
        n_tests++;
        if ({write_a_en, write_b_en, write_b_select, write_b_val, in_ready}
            !== {1'b0, 1'b1, 5'd2, 32'hC0DE, 1'b1}) begin
            n_fail++;
            $display("FAIL starve_place: a_en=%b b=%b/%0d/%h rdy=%b want 0 1/2/c0de rdy=1",
                     write_a_en, write_b_en, write_b_select, write_b_val, in_ready);
        end
        dbg_req = 0; idle();
        tick();
    endtask

    task automatic test_reset_midflight();
        bundle(1, 5'd20, 32'h2020, 1, 5'd21, 32'h2121);
        dbg_req = 1; dbg_reg = 5'd12; dbg_val = 32'h1212;
        tick();  // bundle accepted, debug waits
        reset = 1; #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
        tick();
        n_tests++;
        if ({write_a_en, write_a_select, write_a_val, write_b_en, write_b_select, write_b_val,
             dbg_ack, coll_err} !== 78'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: a=%b/%0d b=%b/%0d ack=%b want all 0",
                     write_a_en, write_a_select, write_b_en, write_b_select, dbg_ack);
        end
        tick();
        n_tests++;
        if ({dbg_ack, in_ready} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_hold: ack=%b rdy=%b want 0 0", dbg_ack, in_ready);
        end
        reset = 0; idle();
        tick();
        n_tests++;
        if ({dbg_ack, write_b_en, write_b_select, write_b_val} !== {1'b1, 1'b1, 5'd12, 32'h1212}) begin
            n_fail++;
            $display("FAIL midrst_serve: ack=%b b=%b/%0d/%h want 1 1/12/1212",
                     dbg_ack, write_b_en, write_b_select, write_b_val);
        end
        dbg_req = 0;
        tick();
    endtask

    // Randomized traffic: the model fills an array of two ports from the
    // slot rules, then hands the first free port (B, then A) to debug.
    task automatic test_random();
        int         m_wait = 0;
        logic       m_ack  = 0;
        logic       e_en[2];
        logic [4:0] e_sel[2];
        logic [31:0] e_val[2];
        logic       e_ack, e_coll, e_ready, clash;
        int         slot;
        reset = 1; idle(); dbg_req = 0;
        tick();
        reset = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            reset    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_a_en  = 1'($urandom_range(0, 1));
            in_b_en  = 1'($urandom_range(0, 1));
            in_a_reg = 5'($urandom_range(0, 7));
            in_b_reg = 5'($urandom_range(0, 7));
            in_a_val = $urandom;
            in_b_val = $urandom;
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req = 1; dbg_reg = 5'($urandom_range(0, 7)); dbg_val = $urandom;
            end
            #1;
            e_ready = !reset && (m_wait < WM);
            n_tests++;
            if (in_ready !== e_ready) begin
                n_fail++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, in_ready, e_ready);
            end
            for (int p = 0; p < 2; p++) begin e_en[p] = 0; e_sel[p] = 0; e_val[p] = 0; end
            e_ack = 0; e_coll = 0;
            if (e_ready && in_valid) begin
                if (in_a_en) begin e_en[0] = 1; e_sel[0] = in_a_reg; e_val[0] = in_a_val; end
                if (in_b_en) begin
                    if (in_a_en && in_a_reg == in_b_reg) e_coll = 1;
                    else begin e_en[1] = 1; e_sel[1] = in_b_reg; e_val[1] = in_b_val; end
                end
            end
            if (reset || !dbg_req) begin
                m_wait = 0;
            end else if (!m_ack) begin
                clash = (e_en[0] && e_sel[0] == dbg_reg) || (e_en[1] && e_sel[1] == dbg_reg);
                slot = !e_en[1] ? 1 : (!e_en[0] ? 0 : -1);
                if (!clash && slot >= 0) begin
                    e_en[slot] = 1; e_sel[slot] = dbg_reg; e_val[slot] = dbg_val;
                    e_ack = 1; m_wait = 0;
                end else if (m_wait < 15) begin
                    m_wait++;
                end
            end
            if (reset) begin
                for (int p = 0; p < 2; p++) begin e_en[p] = 0; e_sel[p] = 0; e_val[p] = 0; end
                e_ack = 0; e_coll = 0;
            end
            m_ack = e_ack;
            tick();
            n_tests++;
            if (write_a_en !== e_en[0] || ((e_en[0] || reset) &&
                (write_a_select !== e_sel[0] || write_a_val !== e_val[0]))) begin
                n_fail++;
                $display("FAIL rnd_port_a cyc%0d: got %b/%0d/%h want %b/%0d/%h", cyc,
                         write_a_en, write_a_select, write_a_val, e_en[0], e_sel[0], e_val[0]);
            end
            n_tests++;
            if (write_b_en !== e_en[1] || ((e_en[1] || reset) &&
                (write_b_select !== e_sel[1] || write_b_val !== e_val[1]))) begin
                n_fail++;
                $display("FAIL rnd_port_b cyc%0d: got %b/%0d/%h want %b/%0d/%h", cyc,
                         write_b_en, write_b_select, write_b_val, e_en[1], e_sel[1], e_val[1]);
            end
            n_tests++;
            if ({dbg_ack, coll_err} !== {e_ack, e_coll}) begin
                n_fail++;
                $display("FAIL rnd_flags cyc%0d: ack/coll=%b%b want %b%b", cyc, dbg_ack, coll_err, e_ack, e_coll);
            end
            n_tests++;
            if (write_a_en && write_b_en && write_a_select == write_b_select) begin
                n_fail++;
                $display("FAIL rnd_same_reg cyc%0d: both ports write r%0d", cyc, write_a_select);
            end
            if (dbg_ack) begin
                dbg_req = 1'($urandom_range(0, 1));
                dbg_reg = 5'($urandom_range(0, 7));
                dbg_val = $urandom;
            end
        end
        reset = 0; idle(); dbg_req = 0;
        tick(); tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_collision();
        test_debug_free();
        test_starvation();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
